// File: rtl/uart_apb_host.sv
// rtl/uart_apb_host.sv - UART command initiator for the uart2apb bridge
// Define UART_HOST_TIMEOUT_EN to bound the wait for a read response.
module uart_apb_host #(
  parameter int CLK_PER_BIT    = 433,
  parameter int GAP_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        tx,
  input  logic        rx,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int CNT_MAX = (CLK_PER_BIT > GAP_CYCLES) ? CLK_PER_BIT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, TX_BYTE, TX_GAP, RX_WAIT, RX_BYTE, DONE} state_t;

  state_t           state;
  logic [55:0]      frame;
  logic [10:0]      tx_sr;
  logic [2:0]       bytes_left;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] cnt;
  logic             is_write;
  logic             err;
  logic             rx_meta, rx_sync, rx_prev;
  logic [7:0]       rx_sr;
  logic [31:0]      rx_data;
  logic [1:0]       rx_count;
`ifdef UART_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_END = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0]  to_cnt;
`endif

  // Line order: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame      <= '0;
      tx_sr      <= '1;
      bytes_left <= '0;
      bit_idx    <= '0;
      cnt        <= '0;
      is_write   <= 1'b0;
      err        <= 1'b0;
      rx_sr      <= '0;
      rx_data    <= '0;
      rx_count   <= '0;
      tx         <= 1'b1;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
`ifdef UART_HOST_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          is_write  <= cmd_write;
          err       <= 1'b0;
          rx_data   <= '0;
          rx_count  <= '0;
          tx        <= 1'b0;
          cnt       <= '0;
          bit_idx   <= '0;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= TX_BYTE;
          if (cmd_write) begin
            frame      <= {8'hA5, cmd_addr, cmd_wdata};
            bytes_left <= 3'd6;
            tx_sr      <= frame_bits(8'hA5);
          end else begin
            frame      <= {8'h5A, cmd_addr, 32'h0};
            bytes_left <= 3'd2;
            tx_sr      <= frame_bits(8'h5A);
          end
        end
        TX_BYTE: if (cnt == BIT_END) begin
          cnt <= '0;
          if (bit_idx == 4'd10) begin
            bit_idx <= '0;
            tx      <= 1'b1;
            if (bytes_left != 3'd0) begin
              state      <= TX_GAP;
              frame      <= frame << 8;
              bytes_left <= bytes_left - 1'b1;
            end else if (is_write) begin
              state     <= IDLE;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end else begin
              state  <= RX_WAIT;
`ifdef UART_HOST_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx      <= tx_sr[1];
            tx_sr   <= {1'b1, tx_sr[10:1]};
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        TX_GAP: if (cnt == GAP_END) begin
          cnt   <= '0;
          tx_sr <= frame_bits(frame[55:48]);
          tx    <= 1'b0;
          state <= TX_BYTE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RX_WAIT: if (rx_prev && !rx_sync) begin
          state   <= RX_BYTE;
          cnt     <= '0;
          bit_idx <= '0;
        end
        RX_BYTE: if ((bit_idx == 4'd0 && cnt == HALF_END) || (bit_idx != 4'd0 && cnt == BIT_END)) begin
          cnt     <= '0;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 4'd0) begin
            if (rx_sync) state <= RX_WAIT;
          end else if (bit_idx <= 4'd8) begin
            rx_sr <= {rx_sync, rx_sr[7:1]};
          end else if (bit_idx == 4'd9) begin
            if (rx_sync != ~^rx_sr) err <= 1'b1;
          end else begin
            // Leave at mid-stop so the next start edge cannot be missed.
            rx_data <= {rx_data[23:0], rx_sr};
            if (rx_count == 2'd3) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_rdata <= {rx_data[23:0], rx_sr};
              rsp_err   <= err | ~rx_sync;
            end else begin
              state    <= RX_WAIT;
              rx_count <= rx_count + 1'b1;
              if (!rx_sync) err <= 1'b1;
            end
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
`ifdef UART_HOST_TIMEOUT_EN
      // One budget covers the whole response, not each byte.
      if (state == RX_WAIT || state == RX_BYTE) begin
        to_cnt <= to_cnt + 1'b1;
        if (to_cnt == TO_END) begin
          state     <= DONE;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
`endif
    end
  end
endmodule
